mem_port_arbiter: RTL and testbench

- Shares the single unified memory port between two requesters: the instruction fetch stage (I-side, read-only) and the memory-access stage (D-side, read/write).
- Every port uses the core's start/ready/valid handshake.
- Grants one transaction at a time, with fixed priority to the D-side.
- Steers the response back to the owner, and supports back-to-back issue in the cycle the response returns.

---
 rtl/mem_port_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the unified memory port: D-side has fixed priority, one transaction outstanding.
// Optional grant/conflict counters are enabled with `define MEM_PORT_ARBITER_PERF_EN.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    output logic                  i_ready,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  i_valid,
    input  logic                  d_start,
    output logic                  d_ready,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic                  d_wen,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_valid,
    output logic                  mem_start,
    input  logic                  mem_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_wen,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_valid,
    output logic [31:0]           perf_i_grants,
    output logic [31:0]           perf_d_grants,
    output logic [31:0]           perf_conflicts
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D
    } state_t;

    state_t state;
    state_t state_next;
    logic   issue_ok;
    logic   d_issue;
    logic   i_issue;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A new issue is allowed while idle or in the cycle the outstanding response returns.
    always_comb begin
        issue_ok   = !rst && mem_ready && (state == IDLE || mem_valid);
        d_ready    = issue_ok;
        i_ready    = issue_ok && !d_start;
        d_issue    = d_ready && d_start;
        i_issue    = i_ready && i_start;

        mem_start  = 1'b0;
        mem_addr   = '0;
        mem_wen    = 1'b0;
        mem_wdata  = '0;
        if (d_issue) begin
            mem_start = 1'b1;
            mem_addr  = d_addr;
            mem_wen   = d_wen;
            mem_wdata = d_wdata;
        end else if (i_issue) begin
            mem_start = 1'b1;
            mem_addr  = i_addr;
        end

        i_valid    = !rst && mem_valid && (state == BUSY_I);
        d_valid    = !rst && mem_valid && (state == BUSY_D);
        i_rdata    = mem_rdata;
        d_rdata    = mem_rdata;

        state_next = state;
        if (d_issue) begin
            state_next = BUSY_D;
        end else if (i_issue) begin
            state_next = BUSY_I;
        end else if (mem_valid) begin
            state_next = IDLE;
        end
    end

`ifdef MEM_PORT_ARBITER_PERF_EN
    logic [31:0] i_grants_q;
    logic [31:0] d_grants_q;
    logic [31:0] conflicts_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            i_grants_q  <= '0;
            d_grants_q  <= '0;
            conflicts_q <= '0;
        end else begin
            if (i_issue) begin
                i_grants_q <= i_grants_q + 32'd1;
            end
            if (d_issue) begin
                d_grants_q <= d_grants_q + 32'd1;
            end
            if (issue_ok && i_start && d_start) begin
                conflicts_q <= conflicts_q + 32'd1;
            end
        end
    end

    assign perf_i_grants  = i_grants_q;
    assign perf_d_grants  = d_grants_q;
    assign perf_conflicts = conflicts_q;
`else
    assign perf_i_grants  = '0;
    assign perf_d_grants  = '0;
    assign perf_conflicts = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a behavioural memory with programmable latency answers
// every accepted request, and each i_valid/d_valid pulse is matched against the queued expectation.
module tb_mem_port_arbiter;

    typedef struct {
        logic        side;   // 1 = D-side, 0 = I-side
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        i_start;
    logic        i_ready;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_valid;
    logic        d_start;
    logic        d_ready;
    logic [31:0] d_addr;
    logic        d_wen;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        mem_start;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_valid;
    logic [31:0] perf_i_grants;
    logic [31:0] perf_d_grants;
    logic [31:0] perf_conflicts;

    int errors = 0;
    int checks = 0;

    exp_t        sb[$];
    logic [31:0] mem_arr[logic [31:0]];

    // memory model state
    logic        mem_auto  = 1'b1;
    int          mem_lat   = 1;
    int          cnt       = 0;
    logic        acc       = 1'b0;
    logic [31:0] acc_addr  = '0;
    logic        acc_wen   = 1'b0;
    logic [31:0] p_addr    = '0;
    logic        p_wen     = 1'b0;
    logic        man_valid = 1'b0;
    logic [31:0] man_rdata = '0;

    mem_port_arbiter #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_start       (i_start),
        .i_ready       (i_ready),
        .i_addr        (i_addr),
        .i_rdata       (i_rdata),
        .i_valid       (i_valid),
        .d_start       (d_start),
        .d_ready       (d_ready),
        .d_addr        (d_addr),
        .d_wen         (d_wen),
        .d_wdata       (d_wdata),
        .d_rdata       (d_rdata),
        .d_valid       (d_valid),
        .mem_start     (mem_start),
        .mem_ready     (mem_ready),
        .mem_addr      (mem_addr),
        .mem_wen       (mem_wen),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .mem_valid     (mem_valid),
        .perf_i_grants (perf_i_grants),
        .perf_d_grants (perf_d_grants),
        .perf_conflicts(perf_conflicts)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] rd(input logic [31:0] a);
        if (mem_arr.exists(a)) return mem_arr[a];
        return {a[15:0], ~a[15:0]};
    endfunction

    // Advance one cycle: score responses and capture requests at negedge, then update the memory model.
    task automatic cyc();
        exp_t        e;
        logic [31:0] got;
        @(negedge clk);
        if (i_valid || d_valid) begin
            checks++;
            if (i_valid && d_valid) begin
                errors++;
                $display("FAIL sb_both_valid: got i_valid=1 d_valid=1, required one side only");
            end else if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got i_valid=%0b d_valid=%0b, required no response", i_valid, d_valid);
            end else begin
                e   = sb.pop_front();
                got = d_valid ? d_rdata : i_rdata;
                if (d_valid !== e.side || got !== e.data) begin
                    errors++;
                    $display("FAIL sb_response: got side=%0b data=%08h, required side=%0b data=%08h",
                             d_valid, got, e.side, e.data);
                end
            end
        end
        acc      = mem_start;
        acc_addr = mem_addr;
        acc_wen  = mem_wen;
        if (mem_start && mem_wen) mem_arr[mem_addr] = mem_wdata;
        @(posedge clk);
        #1;
        if (mem_auto) begin
            mem_valid = 1'b0;
            mem_rdata = '0;
            if (acc) begin
                cnt    = mem_lat;
                p_addr = acc_addr;
                p_wen  = acc_wen;
            end
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    mem_valid = 1'b1;
                    mem_rdata = p_wen ? 32'h0 : rd(p_addr);
                end
            end
        end else begin
            cnt       = 0;
            mem_valid = man_valid;
            mem_rdata = man_rdata;
        end
    endtask

    task automatic push(input logic side, input logic [31:0] data);
        exp_t e;
        e.side = side;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_ready = 1'b1; i_start = 1'b1; d_start = 1'b1;
        cyc(); cyc();
        #1;
        checks++; if (i_ready !== 1'b0 || d_ready !== 1'b0) begin errors++;
            $display("FAIL reset_ready: got i_ready=%0b d_ready=%0b, required 0 0", i_ready, d_ready); end
        checks++; if (mem_start !== 1'b0) begin errors++;
            $display("FAIL reset_mem_start: got %0b, required 0", mem_start); end
        checks++; if (perf_i_grants !== 32'h0 || perf_d_grants !== 32'h0 || perf_conflicts !== 32'h0) begin errors++;
            $display("FAIL reset_perf: got %0d %0d %0d, required 0 0 0", perf_i_grants, perf_d_grants, perf_conflicts); end
        cyc();
        rst = 1'b0; i_start = 1'b0; d_start = 1'b0;
        #1;
        checks++; if (i_ready !== 1'b1 || d_ready !== 1'b1) begin errors++;
            $display("FAIL reset_idle_ready: got i_ready=%0b d_ready=%0b, required 1 1", i_ready, d_ready); end
    endtask

    task automatic test_single_i();
        mem_lat = 2;
        cyc();
        i_start = 1'b1; i_addr = 32'h100;
        #1;
        checks++; if (mem_start !== 1'b1 || mem_addr !== 32'h100 || mem_wen !== 1'b0) begin errors++;
            $display("FAIL single_issue: got start=%0b addr=%08h wen=%0b, required 1 00000100 0", mem_start, mem_addr, mem_wen); end
        push(1'b0, 32'h13);
        cyc();
        i_start = 1'b0;
        #1;
        checks++; if (i_ready !== 1'b0 || mem_start !== 1'b0) begin errors++;
            $display("FAIL single_busy: got i_ready=%0b mem_start=%0b, required 0 0", i_ready, mem_start); end
        cyc();
        #1;
        checks++; if (i_valid !== 1'b1 || i_rdata !== 32'h13 || d_valid !== 1'b0) begin errors++;
            $display("FAIL single_resp: got i_valid=%0b i_rdata=%08h d_valid=%0b, required 1 00000013 0", i_valid, i_rdata, d_valid); end
        cyc();
        #1;
        checks++; if (d_ready !== 1'b1 || mem_valid !== 1'b0) begin errors++;
            $display("FAIL single_idle: got d_ready=%0b, required 1", d_ready); end
    endtask

    task automatic test_conflict();
        mem_lat = 2;
        cyc();
        i_start = 1'b1; i_addr = 32'h100;
        d_start = 1'b1; d_addr = 32'h2000; d_wen = 1'b1; d_wdata = 32'hDEADBEEF;
        #1;
        checks++; if (mem_addr !== 32'h2000 || mem_wen !== 1'b1 || mem_wdata !== 32'hDEADBEEF) begin errors++;
            $display("FAIL conflict_mem: got addr=%08h wen=%0b wdata=%08h, required 00002000 1 deadbeef", mem_addr, mem_wen, mem_wdata); end
        checks++; if (i_ready !== 1'b0 || d_ready !== 1'b1) begin errors++;
            $display("FAIL conflict_ready: got i_ready=%0b d_ready=%0b, required 0 1", i_ready, d_ready); end
        push(1'b1, 32'h0);
        cyc();
        d_start = 1'b0; d_wen = 1'b0;
        #1;
        checks++; if (i_ready !== 1'b0 || mem_start !== 1'b0) begin errors++;
            $display("FAIL conflict_busy: got i_ready=%0b mem_start=%0b, required 0 0", i_ready, mem_start); end
        cyc();
        #1;
        checks++; if (d_valid !== 1'b1 || i_ready !== 1'b1 || mem_start !== 1'b1 || mem_addr !== 32'h100 || mem_wen !== 1'b0) begin errors++;
            $display("FAIL conflict_b2b: got d_valid=%0b i_ready=%0b start=%0b addr=%08h wen=%0b, required 1 1 1 00000100 0",
                     d_valid, i_ready, mem_start, mem_addr, mem_wen); end
        push(1'b0, 32'h13);
        cyc();
        i_start = 1'b0;
        cyc();
        #1;
        checks++; if (i_valid !== 1'b1) begin errors++;
            $display("FAIL conflict_i_resp: got i_valid=%0b, required 1", i_valid); end
        cyc();
    endtask

    task automatic test_d_readback();
        mem_lat = 1;
        cyc();
        d_start = 1'b1; d_addr = 32'h2000; d_wen = 1'b0;
        push(1'b1, 32'hDEADBEEF);
        cyc();
        d_start = 1'b0;
        #1;
        checks++; if (d_valid !== 1'b1 || d_rdata !== 32'hDEADBEEF || i_valid !== 1'b0) begin errors++;
            $display("FAIL readback: got d_valid=%0b d_rdata=%08h i_valid=%0b, required 1 deadbeef 0", d_valid, d_rdata, i_valid); end
        cyc();
    endtask

    task automatic test_back_to_back();
        mem_lat = 1;
        cyc();
        i_start = 1'b1; i_addr = 32'h0;
        push(1'b0, 32'h0000FFFF);
        for (int k = 1; k <= 2; k++) begin
            cyc();
            i_addr = 32'(4 * k);
            #1;
            checks++; if (i_valid !== 1'b1 || mem_start !== 1'b1 || mem_addr !== 32'(4 * k)) begin errors++;
                $display("FAIL b2b_grant%0d: got i_valid=%0b start=%0b addr=%08h, required 1 1 %08h", k, i_valid, mem_start, mem_addr, 4 * k); end
            push(1'b0, rd(32'(4 * k)));
        end
        cyc();
        i_start = 1'b0;
        #1;
        checks++; if (i_valid !== 1'b1 || mem_start !== 1'b0) begin errors++;
            $display("FAIL b2b_last: got i_valid=%0b mem_start=%0b, required 1 0", i_valid, mem_start); end
        cyc();
        #1;
        checks++; if (d_ready !== 1'b1 || i_valid !== 1'b0) begin errors++;
            $display("FAIL b2b_idle: got d_ready=%0b i_valid=%0b, required 1 0", d_ready, i_valid); end
    endtask

    task automatic test_busy_block();
        cyc();
        mem_ready = 1'b0; i_start = 1'b1; i_addr = 32'h100;
        #1;
        checks++; if (i_ready !== 1'b0 || d_ready !== 1'b0 || mem_start !== 1'b0) begin errors++;
            $display("FAIL notready_block: got i_ready=%0b d_ready=%0b start=%0b, required 0 0 0", i_ready, d_ready, mem_start); end
        mem_lat = 3;
        cyc();
        mem_ready = 1'b1; i_start = 1'b0;
        d_start = 1'b1; d_addr = 32'h40; d_wen = 1'b0;
        push(1'b1, rd(32'h40));
        for (int k = 0; k < 2; k++) begin
            cyc();
            d_start = 1'b0; i_start = 1'b1;
            #1;
            checks++; if (i_ready !== 1'b0 || d_ready !== 1'b0 || mem_start !== 1'b0) begin errors++;
                $display("FAIL busy_block%0d: got i_ready=%0b d_ready=%0b start=%0b, required 0 0 0", k, i_ready, d_ready, mem_start); end
        end
        cyc();
        i_start = 1'b0;
        #1;
        checks++; if (d_valid !== 1'b1) begin errors++;
            $display("FAIL busy_resp: got d_valid=%0b, required 1", d_valid); end
        cyc();
    endtask

    task automatic test_reset_mid();
        mem_auto = 1'b0; man_valid = 1'b0; man_rdata = 32'hBAD0BAD0;
        cyc();
        i_start = 1'b1; i_addr = 32'h300;
        #1;
        checks++; if (mem_start !== 1'b1 || mem_addr !== 32'h300) begin errors++;
            $display("FAIL rstmid_issue: got start=%0b addr=%08h, required 1 00000300", mem_start, mem_addr); end
        cyc();
        i_start = 1'b0; rst = 1'b1;
        cyc();
        rst = 1'b0;
        man_valid = 1'b1;
        cyc();
        man_valid = 1'b0;
        #1;
        checks++; if (mem_valid !== 1'b1 || i_valid !== 1'b0 || d_valid !== 1'b0) begin errors++;
            $display("FAIL rstmid_stray: got mem_valid=%0b i_valid=%0b d_valid=%0b, required 1 0 0", mem_valid, i_valid, d_valid); end
        cyc();
        #1;
        checks++; if (d_ready !== 1'b1 || i_ready !== 1'b1) begin errors++;
            $display("FAIL rstmid_idle: got d_ready=%0b i_ready=%0b, required 1 1", d_ready, i_ready); end
        mem_auto = 1'b1;
    endtask

    task automatic test_perf();
        logic [31:0] exp_i, exp_d, exp_c;
`ifdef MEM_PORT_ARBITER_PERF_EN
        exp_i = 32'd4; exp_d = 32'd1; exp_c = 32'd1;
`else
        exp_i = 32'd0; exp_d = 32'd0; exp_c = 32'd0;
`endif
        test_reset();
        test_conflict();
        test_back_to_back();
        #1;
        checks++; if (perf_i_grants !== exp_i || perf_d_grants !== exp_d || perf_conflicts !== exp_c) begin errors++;
            $display("FAIL perf_counts: got i=%0d d=%0d c=%0d, required i=%0d d=%0d c=%0d",
                     perf_i_grants, perf_d_grants, perf_conflicts, exp_i, exp_d, exp_c); end
    endtask

    initial begin
        rst = 1'b1; i_start = 1'b0; i_addr = '0; d_start = 1'b0; d_addr = '0;
        d_wen = 1'b0; d_wdata = '0; mem_ready = 1'b1; mem_rdata = '0; mem_valid = 1'b0;
        mem_arr[32'h100] = 32'h13;
        test_reset();
        test_single_i();
        test_conflict();
        test_d_readback();
        test_back_to_back();
        test_busy_block();
        test_reset_mid();
        test_perf();
        cyc();
        checks++; if (sb.size() != 0) begin errors++;
            $display("FAIL sb_drain: got %0d pending responses, required 0", sb.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
